// File: rtl/q_axil_master.sv
// AXI4-Lite initiator for the Q-function slave: writes X/T/N/alpha, starts the core,
// polls STATUS until done, then reads Q back and reports it on the result port.
module q_axil_master #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                POLL_LIMIT = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_x,
    input  logic [31:0]       cmd_t,
    input  logic [31:0]       cmd_n,
    input  logic [31:0]       cmd_alpha,
    output logic              res_valid,
    output logic [31:0]       res_q,
    output logic [1:0]        res_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_FIN} state_t;

    localparam logic [15:0]       POLL_MAX   = 16'(POLL_LIMIT - 1);
    localparam logic [ADDR_W-1:0] ADR_STATUS = BASE_ADDR + ADDR_W'(32'h14);
    localparam logic [ADDR_W-1:0] ADR_Q      = BASE_ADDR + ADDR_W'(32'h18);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       x_q, x_d, t_q, t_d, n_q, n_d, alpha_q, alpha_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q_phase_q, rd_q_phase_d;
    logic [15:0]       poll_cnt_q, poll_cnt_d;
    logic [31:0]       res_q_q, res_q_d;
    logic [1:0]        res_err_q, res_err_d;

    logic [2:0]  idx_inc;
    logic [31:0] nxt_wdata;
    logic        aw_fin, w_fin;

    // Operand for the write that follows the current index (index 4 is CTRL.start).
    always_comb begin
        idx_inc = idx_q + 3'd1;
        case (idx_inc)
            3'd1:    nxt_wdata = t_q;
            3'd2:    nxt_wdata = n_q;
            3'd3:    nxt_wdata = alpha_q;
            default: nxt_wdata = 32'd1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        t_d          = t_q;
        n_d          = n_q;
        alpha_d      = alpha_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        rd_q_phase_d = rd_q_phase_q;
        poll_cnt_d   = poll_cnt_q;
        res_q_d      = res_q_q;
        res_err_d    = res_err_q;
        aw_fin       = aw_done_q | m_awready;
        w_fin        = w_done_q | m_wready;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_d        = cmd_x;
                    t_d        = cmd_t;
                    n_d        = cmd_n;
                    alpha_d    = cmd_alpha;
                    idx_d      = 3'd0;
                    awaddr_d   = BASE_ADDR;
                    wdata_d    = cmd_x;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    poll_cnt_d = 16'd0;
                    state_d    = S_WR;
                end
            end
            S_WR: begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) state_d = S_WB;
            end
            S_WB: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        res_err_d = 2'd1;
                        state_d   = S_FIN;
                    end else if (idx_q == 3'd4) begin
                        araddr_d     = ADR_STATUS;
                        rd_q_phase_d = 1'b0;
                        state_d      = S_RA;
                    end else begin
                        idx_d     = idx_inc;
                        awaddr_d  = BASE_ADDR + ADDR_W'({idx_inc, 2'b00});
                        wdata_d   = nxt_wdata;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR;
                    end
                end
            end
            S_RA: begin
                if (m_arready) state_d = S_RD;
            end
            S_RD: begin
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        res_err_d = 2'd1;
                        state_d   = S_FIN;
                    end else if (rd_q_phase_q) begin
                        res_q_d   = m_rdata;
                        res_err_d = 2'd0;
                        state_d   = S_FIN;
                    end else if (m_rdata[0]) begin
                        araddr_d     = ADR_Q;
                        rd_q_phase_d = 1'b1;
                        state_d      = S_RA;
                    end else if (poll_cnt_q < POLL_MAX) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        state_d    = S_RA;
                    end else begin
                        res_err_d = 2'd2;
                        state_d   = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            x_q          <= '0;
            t_q          <= '0;
            n_q          <= '0;
            alpha_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            rd_q_phase_q <= 1'b0;
            poll_cnt_q   <= '0;
            res_q_q      <= '0;
            res_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            t_q          <= t_d;
            n_q          <= n_d;
            alpha_q      <= alpha_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            rd_q_phase_q <= rd_q_phase_d;
            poll_cnt_q   <= poll_cnt_d;
            res_q_q      <= res_q_d;
            res_err_q    <= res_err_d;
        end
    end

    // Valids come only from flops, so they never follow ready combinationally.
    assign cmd_ready = (state_q == S_IDLE) && !areset;
    assign res_valid = (state_q == S_FIN);
    assign res_q     = res_q_q;
    assign res_err   = res_err_q;
    assign m_awaddr  = awaddr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state_q == S_WR) && !aw_done_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = (state_q == S_WR) && !w_done_q;
    assign m_bready  = (state_q == S_WB);
    assign m_araddr  = araddr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state_q == S_RA);
    assign m_rready  = (state_q == S_RD);

endmodule

// File: tb/tb_q_axil_master.sv
// Scoreboard bench for q_axil_master: a behavioural AXI4-Lite slave checks each write/read
// against queued expectations, and a result monitor checks res_q/res_err and latency.
module tb_q_axil_master;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          PL   = 8;

    logic        aclk, areset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_x, cmd_t, cmd_n, cmd_alpha;
    logic        res_valid;
    logic [31:0] res_q;
    logic [1:0]  res_err;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    q_axil_master #(.ADDR_W(32), .BASE_ADDR(BASE), .POLL_LIMIT(PL)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_t(cmd_t), .cmd_n(cmd_n), .cmd_alpha(cmd_alpha),
        .res_valid(res_valid), .res_q(res_q), .res_err(res_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] q;
        logic [1:0]  err;
        int          lat;
    } res_t;

    logic [63:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    res_t        exp_res[$];

    int n_cmp = 0;
    int n_err = 0;
    int rd_seen = 0;
    int res_seen = 0;
    int cyc = 0;

    // slave configuration
    int          aw_dly = 0, w_dly = 0, done_after = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF, q_val = 32'h0;

    // slave state
    int          aw_wait, w_wait, poll_idx;
    logic        have_aw, have_w, aw_stall, w_stall;
    logic [31:0] cap_awaddr, cap_wdata, aw_prev, w_prev;
    logic        g_aw, g_w;
    logic [31:0] a_addr, a_data;
    logic [63:0] e_wr;
    logic [31:0] e_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    assign m_awready = (aw_wait >= aw_dly);
    assign m_wready  = (w_wait >= w_dly);
    assign m_arready = 1'b1;

    always @(posedge aclk) begin
        if (areset) begin
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= 32'h0;
            aw_wait <= 0; w_wait <= 0;
            have_aw <= 1'b0; have_w <= 1'b0;
            aw_stall <= 1'b0; w_stall <= 1'b0;
        end else begin
            if (aw_stall) begin
                chk("aw_hold_valid", m_awvalid, 1);
                chk("aw_hold_addr", m_awaddr, aw_prev);
            end
            if (w_stall) begin
                chk("w_hold_valid", m_wvalid, 1);
                chk("w_hold_data", m_wdata, w_prev);
            end
            aw_stall <= m_awvalid && !m_awready;
            aw_prev  <= m_awaddr;
            w_stall  <= m_wvalid && !m_wready;
            w_prev   <= m_wdata;

            if (m_awvalid && m_awready) aw_wait <= 0;
            else if (m_awvalid) aw_wait <= aw_wait + 1;
            if (m_wvalid && m_wready) w_wait <= 0;
            else if (m_wvalid) w_wait <= w_wait + 1;

            g_aw   = have_aw || (m_awvalid && m_awready);
            g_w    = have_w || (m_wvalid && m_wready);
            a_addr = have_aw ? cap_awaddr : m_awaddr;
            a_data = have_w ? cap_wdata : m_wdata;
            if (m_awvalid && m_awready) cap_awaddr <= m_awaddr;
            if (m_wvalid && m_wready) cap_wdata <= m_wdata;

            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (g_aw && g_w) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h, none expected", a_addr, a_data);
                end else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_addr", a_addr, e_wr[63:32]);
                    chk("wr_data", a_data, e_wr[31:0]);
                end
                if (a_addr == BASE + 32'h10) poll_idx <= 0;
                m_bvalid <= 1'b1;
                m_bresp  <= (a_addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
                have_aw <= g_aw;
                have_w  <= g_w;
            end

            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                rd_seen <= rd_seen + 1;
                if (exp_rd.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_unexpected: got addr %0h, none expected", m_araddr);
                end else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_addr", m_araddr, e_rd);
                end
                m_rvalid <= 1'b1;
                m_rresp  <= 2'b00;
                if (m_araddr == BASE + 32'h14) begin
                    m_rdata  <= (poll_idx >= done_after) ? 32'h1 : 32'h0;
                    poll_idx <= poll_idx + 1;
                end else begin
                    m_rdata <= q_val;
                end
            end
        end
    end

    // cyc counts cycles after the capture edge; the capture cycle itself is 0
    always @(negedge aclk) begin
        if (cmd_valid && cmd_ready) cyc = 0;
        else cyc++;
        if (res_valid) begin
            res_seen++;
            if (exp_res.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL res_unexpected: got q %0h err %0d, none expected", res_q, res_err);
            end else begin
                res_t r;
                r = exp_res.pop_front();
                chk("res_q", res_q, r.q);
                chk("res_err", res_err, r.err);
                chk("res_latency", cyc, r.lat);
            end
        end
    end

    task automatic push_writes(input logic [31:0] x, t, n, a, input int count);
        logic [31:0] d[5];
        d[0] = x; d[1] = t; d[2] = n; d[3] = a; d[4] = 32'h1;
        for (int i = 0; i < count; i++)
            exp_wr.push_back({BASE + 32'(i * 4), d[i]});
    endtask

    task automatic push_reads(input int polls, input bit qread);
        for (int i = 0; i < polls; i++) exp_rd.push_back(BASE + 32'h14);
        if (qread) exp_rd.push_back(BASE + 32'h18);
    endtask

    task automatic push_res(input logic [31:0] q, input logic [1:0] err, input int lat);
        res_t r;
        r.q = q; r.err = err; r.lat = lat;
        exp_res.push_back(r);
    endtask

    task automatic issue(input logic [31:0] x, t, n, a);
        bit ok;
        ok = 1'b0;
        @(posedge aclk); #1;
        cmd_x = x; cmd_t = t; cmd_n = n; cmd_alpha = a;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        chk("cmd_accepted", ok, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge aclk);
            if (res_seen >= target) begin ok = 1'b1; break; end
        end
        chk("res_timeout", ok, 1);
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base_rd;
        areset = 1'b1; cmd_valid = 1'b0;
        cmd_x = 0; cmd_t = 0; cmd_n = 0; cmd_alpha = 0;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        chk("rst_addrs", {m_awaddr, m_araddr}, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("const_prot_strb", {m_awprot, m_arprot, m_wstrb}, 64'h00F);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // 1: zero-wait slave, done on the first poll
        q_val = 32'h0000_00A7; done_after = 0;
        push_writes(32, 55, 101, 2, 5); push_reads(1, 1); push_res(32'hA7, 0, 15);
        issue(32, 55, 101, 2);
        wait_res(1);

        // 2: AWREADY late by 3 cycles, WREADY by 1 -> +3 cycles per write
        aw_dly = 3; w_dly = 1; q_val = 32'h55;
        push_writes(32'h1234, 7, 9, 3, 5); push_reads(1, 1); push_res(32'h55, 0, 30);
        issue(32'h1234, 7, 9, 3);
        wait_res(2);
        aw_dly = 0; w_dly = 0;

        // 3: done after four busy polls
        done_after = 4; q_val = 32'h1111;
        push_writes(1, 2, 3, 4, 5); push_reads(5, 1); push_res(32'h1111, 0, 23);
        issue(1, 2, 3, 4);
        wait_res(3);

        // 4: never done -> PL status reads, timeout, res_q retained
        done_after = 1000; q_val = 32'hDEAD_BEEF;
        push_writes(5, 6, 7, 8, 5); push_reads(PL, 0); push_res(32'h1111, 2, 27);
        issue(5, 6, 7, 8);
        wait_res(4);

        // 5: SLVERR on the N write, then a clean command
        err_addr = BASE + 32'h08; done_after = 0;
        push_writes(9, 10, 11, 12, 3); push_res(32'h1111, 1, 7);
        issue(9, 10, 11, 12);
        wait_res(5);
        err_addr = 32'hFFFF_FFFF; q_val = 32'h2222;
        push_writes(13, 14, 15, 16, 5); push_reads(1, 1); push_res(32'h2222, 0, 15);
        issue(13, 14, 15, 16);
        wait_res(6);

        // 6: reset during the poll loop after the third status read
        done_after = 1000;
        base_rd = rd_seen;
        push_writes(17, 18, 19, 20, 5); push_reads(3, 0);
        issue(17, 18, 19, 20);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_seen >= base_rd + 3) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk("reach_poll", ok, 1);
        areset = 1'b1;
        @(negedge aclk);
        chk("arst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_res_valid", res_valid, 0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        done_after = 0; q_val = 32'h3333;
        push_writes(21, 22, 23, 24, 5); push_reads(1, 1); push_res(32'h3333, 0, 15);
        issue(21, 22, 23, 24);
        wait_res(7);

        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_rd_left", exp_rd.size(), 0);
        chk("exp_res_left", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
